// File: rtl/beat_sched_pkg.sv
// Shared types and defaults for the beat-driven note scheduler.
package beat_sched_pkg;

    // Scheduler states; encoding is visible on the debug port.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_PLAY  = 2'd2,
        ST_GAP   = 2'd3
    } sched_state_t;

    localparam int DEF_NOTE_W = 6;
    localparam int DEF_DUR_W  = 6;

    // One queued request at the default widths: {note, duration}.
    typedef struct packed {
        logic [DEF_NOTE_W-1:0] note;
        logic [DEF_DUR_W-1:0]  duration;
    } sched_entry_t;

    // Width of the gap counter; at least one bit even when gaps are disabled.
    function automatic int gap_cnt_width(input int gap_beats);
        return (gap_beats < 2) ? 1 : $clog2(gap_beats + 1);
    endfunction

endpackage

// File: rtl/note_skid_buf.sv
// One-entry holding register between the song reader and the scheduler.
// Valid/ready contract: a transfer happens on a clock edge where the
// producer's valid and our ready (= !full) are both high; the producer
// holds its data stable until that edge. The caller only pushes when
// empty and only pops when full, so both never happen in one cycle.
module note_skid_buf #(
    parameter int W = 12
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic         full,
    output logic [W-1:0] dout
);

    // Load on push, release on pop; cleared asynchronously on reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            full <= 1'b0;
            dout <= '0;
        end else if (push) begin
            full <= 1'b1;
            dout <= din;
        end else if (pop) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/beat_scheduler.sv
// Plays (note, duration) requests against the 1/32 s beat tick. Each note
// sounds for exactly `duration` beat periods, optionally followed by a
// silent gap; a one-entry look-ahead buffer makes back-to-back notes
// gapless. play=0 freezes all timing without stopping the input handshake.
module beat_scheduler
    import beat_sched_pkg::*;
#(
    parameter int NOTE_W    = DEF_NOTE_W,
    parameter int DUR_W     = DEF_DUR_W,
    parameter int GAP_BEATS = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              beat,
    input  logic              play,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [NOTE_W-1:0] in_note,
    input  logic [DUR_W-1:0]  in_duration,
    output logic [NOTE_W-1:0] note_out,
    output logic              note_valid,
    output logic              note_done,
    output logic              busy,
    output sched_state_t      state_dbg
);

    localparam int GW = gap_cnt_width(GAP_BEATS);
    localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_BEATS);

    typedef struct packed {
        logic [NOTE_W-1:0] note;
        logic [DUR_W-1:0]  duration;
    } entry_t;

    sched_state_t      state;
    logic [DUR_W-1:0]  rem;
    logic [GW-1:0]     gap_cnt;
    logic              buf_full;
    entry_t            buf_q;
    logic              push;
    logic              pop;
    logic              qbeat;
    logic              next_ok;

    // in_ready is held low during reset even though the buffer reads empty.
    assign in_ready  = reset & ~buf_full;
    assign push      = in_valid & in_ready;
    assign qbeat     = beat & play;
    assign next_ok   = buf_full && (buf_q.duration != '0);
    assign busy      = (state != ST_IDLE) || buf_full;
    assign state_dbg = state;

    note_skid_buf #(
        .W(NOTE_W + DUR_W)
    ) u_buf (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .din   ({in_note, in_duration}),
        .pop   (pop),
        .full  (buf_full),
        .dout  (buf_q)
    );

    // Buffer is drained by IDLE, or at a counted end-of-note/end-of-gap beat
    // when the waiting entry can start immediately.
    always_comb begin
        pop = 1'b0;
        case (state)
            ST_IDLE:  pop = buf_full;
            ST_PLAY:  pop = qbeat && (rem == DUR_W'(1)) && (GAP_BEATS == 0) && next_ok;
            ST_GAP:   pop = qbeat && (gap_cnt == GW'(1)) && next_ok;
            default:  pop = 1'b0;
        endcase
    end

    // Scheduler FSM with registered tone-generator outputs and beat counters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            rem        <= '0;
            gap_cnt    <= '0;
            note_out   <= '0;
            note_valid <= 1'b0;
            note_done  <= 1'b0;
        end else begin
            note_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    note_valid <= 1'b0;
                    note_out   <= '0;
                    if (buf_full) begin
                        // Zero-length entries retire here without sounding.
                        if (buf_q.duration == '0) begin
                            note_done <= 1'b1;
                        end else begin
                            state    <= ST_ARMED;
                            note_out <= buf_q.note;
                            rem      <= buf_q.duration;
                        end
                    end
                end
                ST_ARMED: begin
                    // The note's first beat period starts on the next counted beat.
                    note_valid <= 1'b0;
                    if (qbeat) begin
                        state      <= ST_PLAY;
                        note_valid <= 1'b1;
                    end
                end
                ST_PLAY: begin
                    note_valid <= play;
                    if (qbeat) begin
                        if (rem == DUR_W'(1)) begin
                            note_done <= 1'b1;
                            if (GAP_BEATS != 0) begin
                                state      <= ST_GAP;
                                gap_cnt    <= GAP_LOAD;
                                note_valid <= 1'b0;
                            end else if (next_ok) begin
                                // Legato hand-over: note_valid stays high.
                                note_out <= buf_q.note;
                                rem      <= buf_q.duration;
                            end else begin
                                state      <= ST_IDLE;
                                note_out   <= '0;
                                note_valid <= 1'b0;
                            end
                        end else begin
                            rem <= rem - DUR_W'(1);
                        end
                    end
                end
                ST_GAP: begin
                    // note_out keeps the finished note during the rest.
                    note_valid <= 1'b0;
                    if (qbeat) begin
                        if (gap_cnt == GW'(1)) begin
                            if (next_ok) begin
                                state      <= ST_PLAY;
                                note_out   <= buf_q.note;
                                rem        <= buf_q.duration;
                                note_valid <= 1'b1;
                            end else begin
                                state    <= ST_IDLE;
                                note_out <= '0;
                            end
                        end else begin
                            gap_cnt <= gap_cnt - GW'(1);
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_beat_scheduler.sv
// Bench for beat_scheduler: two instances (legato and one-beat gap) run the
// same kind of stimulus side by side against a beat-level reference model.
module tb_beat_scheduler;
    import beat_sched_pkg::*;

    localparam int GAP0 = 0;
    localparam int GAP1 = 1;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic         beat;
    logic         play;
    logic         in_valid   [2];
    logic [5:0]   in_note    [2];
    logic [5:0]   in_dur     [2];
    logic         in_ready   [2];
    logic [5:0]   note_out   [2];
    logic         note_valid [2];
    logic         note_done  [2];
    logic         busy       [2];
    sched_state_t st         [2];

    beat_scheduler #(.NOTE_W(6), .DUR_W(6), .GAP_BEATS(GAP0)) u_legato (
        .clk(clk), .reset(rst_n), .beat(beat), .play(play),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_note(in_note[0]), .in_duration(in_dur[0]),
        .note_out(note_out[0]), .note_valid(note_valid[0]),
        .note_done(note_done[0]), .busy(busy[0]), .state_dbg(st[0])
    );

    beat_scheduler #(.NOTE_W(6), .DUR_W(6), .GAP_BEATS(GAP1)) u_gapped (
        .clk(clk), .reset(rst_n), .beat(beat), .play(play),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_note(in_note[1]), .in_duration(in_dur[1]),
        .note_out(note_out[1]), .note_valid(note_valid[1]),
        .note_done(note_done[1]), .busy(busy[1]), .state_dbg(st[1])
    );

    // ---------------- checking ----------------
    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model (beat-level) ----------------
    // Per instance: a one-slot pending entry, the length of the held note and
    // how many beats of it have been heard, and rest beats left after a note.
    bit         m_full    [2];
    logic [5:0] m_bnote   [2];
    logic [5:0] m_bdur    [2];
    int         m_len     [2];
    int         m_heard   [2];
    bit         m_started [2];
    int         m_rest    [2];
    logic [5:0] m_note    [2];
    bit         m_valid   [2];
    bit         m_done    [2];
    bit         acc_last  [2];

    // Scoreboard: notes of accepted entries not yet retired.
    logic [5:0] exp_q0[$];
    logic [5:0] exp_q1[$];

    task automatic model_reset(input int k);
        m_full[k] = 0; m_bnote[k] = '0; m_bdur[k] = '0;
        m_len[k] = 0; m_heard[k] = 0; m_started[k] = 0; m_rest[k] = 0;
        m_note[k] = '0; m_valid[k] = 0; m_done[k] = 0;
        if (k == 0) exp_q0.delete(); else exp_q1.delete();
    endtask

    task automatic model_step(input int k, input int gap);
        bit qb, take, go_next, nv, nd;
        logic [5:0] nn;
        qb = beat && play;
        take = 0; go_next = 0; nd = 0;
        nn = m_note[k]; nv = m_valid[k];
        if (m_len[k] == 0 && m_rest[k] == 0) begin
            nv = 0; nn = '0;
            if (m_full[k]) begin
                take = 1;
                if (m_bdur[k] == 0) nd = 1;
                else begin
                    m_len[k] = int'(m_bdur[k]); m_heard[k] = 0; m_started[k] = 0;
                    nn = m_bnote[k];
                end
            end
        end else if (m_rest[k] > 0) begin
            nv = 0;
            if (qb) begin
                m_rest[k]--;
                if (m_rest[k] == 0) go_next = 1;
            end
        end else if (!m_started[k]) begin
            nv = qb;
            if (qb) m_started[k] = 1;
        end else begin
            nv = play;
            if (qb) begin
                m_heard[k]++;
                if (m_heard[k] == m_len[k]) begin
                    nd = 1; m_len[k] = 0;
                    if (gap > 0) begin m_rest[k] = gap; nv = 0; end
                    else go_next = 1;
                end
            end
        end
        if (go_next) begin
            if (m_full[k] && m_bdur[k] != 0) begin
                take = 1; m_len[k] = int'(m_bdur[k]); m_heard[k] = 0; m_started[k] = 1;
                nn = m_bnote[k]; nv = 1;
            end else begin
                nn = '0; nv = 0;
            end
        end
        if (acc_last[k]) begin
            m_full[k] = 1; m_bnote[k] = in_note[k]; m_bdur[k] = in_dur[k];
        end else if (take) begin
            m_full[k] = 0;
        end
        m_note[k] = nn; m_valid[k] = nv; m_done[k] = nd;
    endtask

    // ---------------- measurement counters ----------------
    int nv_cnt [2];
    int nd_cnt [2];
    int nv_rise[2];
    int low_between[2];
    int snd_cnt[2][64];
    bit prev_nv[2];
    int beat_ctr = 0;

    task automatic clear_counters();
        for (int k = 0; k < 2; k++) begin
            nv_cnt[k] = 0; nd_cnt[k] = 0; nv_rise[k] = 0; low_between[k] = 0;
            prev_nv[k] = note_valid[k];
            for (int n = 0; n < 64; n++) snd_cnt[k][n] = 0;
        end
    endtask

    task automatic sb_retire_and_check(input int k);
        int sz;
        logic [5:0] front;
        if (note_done[k]) begin
            sz = (k == 0) ? exp_q0.size() : exp_q1.size();
            check($sformatf("u%0d_sb_done_has_entry", k), (sz > 0), 1);
            if (sz > 0) begin
                if (k == 0) void'(exp_q0.pop_front()); else void'(exp_q1.pop_front());
            end
        end
        if (note_valid[k]) begin
            sz = (k == 0) ? exp_q0.size() : exp_q1.size();
            check($sformatf("u%0d_sb_sound_has_entry", k), (sz > 0), 1);
            if (sz > 0) begin
                front = (k == 0) ? exp_q0[0] : exp_q1[0];
                check($sformatf("u%0d_sb_note", k), note_out[k], front);
            end
        end
    endtask

    // ---------------- driver: one clock cycle ----------------
    task automatic tick();
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            acc_last[k] = rst_n && in_valid[k] && !m_full[k];
            if (!rst_n) model_reset(k);
            else begin
                if (acc_last[k]) begin
                    if (k == 0) exp_q0.push_back(in_note[k]); else exp_q1.push_back(in_note[k]);
                end
                model_step(k, (k == 0) ? GAP0 : GAP1);
            end
        end
        #1;
        for (int k = 0; k < 2; k++) begin
            if (rst_n) begin
                check($sformatf("u%0d_note_out", k),   note_out[k],   m_note[k]);
                check($sformatf("u%0d_note_valid", k), note_valid[k], m_valid[k]);
                check($sformatf("u%0d_note_done", k),  note_done[k],  m_done[k]);
                check($sformatf("u%0d_in_ready", k),   in_ready[k],   !m_full[k]);
                check($sformatf("u%0d_busy", k),       busy[k],
                      (m_full[k] || m_len[k] != 0 || m_rest[k] != 0));
                sb_retire_and_check(k);
                nv_cnt[k] += note_valid[k];
                nd_cnt[k] += note_done[k];
                if (note_valid[k] && !prev_nv[k]) nv_rise[k]++;
                if (!note_valid[k] && busy[k] && nv_rise[k] == 1) low_between[k]++;
                if (note_valid[k]) snd_cnt[k][note_out[k]]++;
                prev_nv[k] = note_valid[k];
            end else begin
                check($sformatf("u%0d_in_ready_rst", k), in_ready[k], 0);
            end
        end
        beat_ctr = (beat_ctr + 1) % 4;
        beat = (beat_ctr == 0);
    endtask

    task automatic push_both(input logic [5:0] n, input logic [5:0] d);
        for (int k = 0; k < 2; k++) begin
            in_valid[k] = 1'b1; in_note[k] = n; in_dur[k] = d;
        end
        for (int t = 0; t < 300; t++) begin
            if (!in_valid[0] && !in_valid[1]) break;
            tick();
            for (int k = 0; k < 2; k++) if (acc_last[k]) in_valid[k] = 1'b0;
        end
        check("push_accepted", {31'b0, in_valid[0] | in_valid[1]}, 0);
        in_valid[0] = 1'b0; in_valid[1] = 1'b0;
    endtask

    task automatic wait_idle();
        for (int t = 0; t < 800; t++) begin
            if (!busy[0] && !busy[1]) break;
            tick();
        end
        check("idle_reached", {31'b0, busy[0] | busy[1]}, 0);
        check("idle_state", st[0], ST_IDLE);
        tick();
        tick();
    endtask

    task automatic wait_sounding();
        for (int t = 0; t < 80; t++) begin
            if (note_valid[0]) break;
            tick();
        end
        check("sounding_reached", note_valid[0], 1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n = 1'b0; beat = 1'b0; play = 1'b1;
        for (int k = 0; k < 2; k++) begin
            in_valid[k] = 1'b0; in_note[k] = '0; in_dur[k] = '0;
            model_reset(k);
        end
        clear_counters();
        repeat (3) tick();

        // Reset values.
        for (int k = 0; k < 2; k++) begin
            check($sformatf("u%0d_rst_note_out", k),   note_out[k],   0);
            check($sformatf("u%0d_rst_note_valid", k), note_valid[k], 0);
            check($sformatf("u%0d_rst_note_done", k),  note_done[k],  0);
            check($sformatf("u%0d_rst_busy", k),       busy[k],       0);
        end
        rst_n = 1'b1;
        tick();

        // 1: single note of 3 beats -> 12 sounding cycles, one done pulse.
        clear_counters();
        push_both(6'h15, 6'd3);
        wait_idle();
        for (int k = 0; k < 2; k++) begin
            check($sformatf("t1_u%0d_sound_cycles", k), snd_cnt[k][6'h15], 12);
            check($sformatf("t1_u%0d_valid_cycles", k), nv_cnt[k], 12);
            check($sformatf("t1_u%0d_done_pulses", k), nd_cnt[k], 1);
            check($sformatf("t1_u%0d_busy_after", k), busy[k], 0);
        end

        // 2/3: two notes; legato on u0, one-beat rest on u1.
        clear_counters();
        push_both(6'h0A, 6'd2);
        push_both(6'h0C, 6'd1);
        wait_idle();
        for (int k = 0; k < 2; k++) begin
            check($sformatf("t2_u%0d_cycles_0A", k), snd_cnt[k][6'h0A], 8);
            check($sformatf("t2_u%0d_cycles_0C", k), snd_cnt[k][6'h0C], 4);
            check($sformatf("t2_u%0d_done_pulses", k), nd_cnt[k], 2);
        end
        check("t2_u0_valid_rises", nv_rise[0], 1);
        check("t2_u0_low_between", low_between[0], 0);
        check("t3_u1_valid_rises", nv_rise[1], 2);
        check("t3_u1_low_between", low_between[1], 4);

        // 4: zero-duration entry retires without sounding.
        clear_counters();
        push_both(6'h07, 6'd0);
        tick();
        tick();
        for (int k = 0; k < 2; k++) check($sformatf("t4_u%0d_busy_quick", k), busy[k], 0);
        repeat (4) tick();
        for (int k = 0; k < 2; k++) begin
            check($sformatf("t4_u%0d_done_pulses", k), nd_cnt[k], 1);
            check($sformatf("t4_u%0d_valid_cycles", k), nv_cnt[k], 0);
        end

        // 5: pause for 10 cycles after the note's second beat.
        clear_counters();
        push_both(6'h11, 6'd4);
        wait_sounding();
        for (int t = 0; t < 8 && !beat; t++) tick();
        tick();
        play = 1'b0;
        repeat (10) tick();
        play = 1'b1;
        wait_idle();
        for (int k = 0; k < 2; k++) begin
            check($sformatf("t5_u%0d_sound_cycles", k), snd_cnt[k][6'h11], 14);
            check($sformatf("t5_u%0d_done_pulses", k), nd_cnt[k], 1);
            check($sformatf("t5_u%0d_valid_rises", k), nv_rise[k], 2);
        end

        // 6: asynchronous reset mid-note with an entry buffered.
        clear_counters();
        push_both(6'h11, 6'd4);
        push_both(6'h22, 6'd3);
        wait_sounding();
        tick();
        #2;
        rst_n = 1'b0;
        for (int k = 0; k < 2; k++) model_reset(k);
        #1;
        for (int k = 0; k < 2; k++) begin
            check($sformatf("t6_u%0d_valid_async", k), note_valid[k], 0);
            check($sformatf("t6_u%0d_note_async", k),  note_out[k],   0);
            check($sformatf("t6_u%0d_busy_async", k),  busy[k],       0);
            check($sformatf("t6_u%0d_ready_async", k), in_ready[k],   0);
        end
        repeat (3) tick();
        rst_n = 1'b1;
        #1;
        for (int k = 0; k < 2; k++) check($sformatf("t6_u%0d_ready_after", k), in_ready[k], 1);
        clear_counters();
        repeat (60) tick();
        for (int k = 0; k < 2; k++) begin
            check($sformatf("t6_u%0d_no_replay", k), nv_cnt[k], 0);
            check($sformatf("t6_u%0d_no_done", k), nd_cnt[k], 0);
        end

        // Randomized traffic with random pauses on both instances.
        for (int t = 0; t < 2500; t++) begin
            tick();
            for (int k = 0; k < 2; k++) begin
                if (acc_last[k]) in_valid[k] = 1'b0;
                if (!in_valid[k] && $urandom_range(0, 3) == 0) begin
                    in_valid[k] = 1'b1;
                    in_note[k]  = 6'($urandom_range(1, 63));
                    if ($urandom_range(0, 7) == 0) in_dur[k] = 6'd0;
                    else if ($urandom_range(0, 40) == 0) in_dur[k] = 6'd63;
                    else in_dur[k] = 6'($urandom_range(1, 5));
                end
            end
            if ($urandom_range(0, 29) == 0) play = !play;
        end
        in_valid[0] = 1'b0; in_valid[1] = 1'b0;
        play = 1'b1;
        wait_idle();
        check("sb_u0_all_retired", exp_q0.size(), 0);
        check("sb_u1_all_retired", exp_q1.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/beat_scheduler.md
Name: beat_scheduler

Overview:
- Sequences timed note playback from the 1/32-second beat tick produced by the beat counter.
- Accepts (note, duration) pairs over a valid/ready handshake and holds each note for exactly `duration` beats.
- Optional silent gap between notes; pause control freezes timing.
- One-entry look-ahead buffer gives gapless back-to-back playback; sits between the song ROM/reader and the tone generator.

Parameters:
- NOTE_W, 6, width of note code.
- DUR_W, 6, width of duration field, in beats.
- GAP_BEATS, 0, silent beats inserted after every note (0 = legato).

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- beat  input  1  one-cycle pulse, one per beat period, from the beat counter.
- play  input  1  level; 0 = pause.
- in_valid  input  1  in_note/in_duration valid.
- in_ready  output  1  buffer can accept.
- in_note  input  NOTE_W  note code.
- in_duration  input  DUR_W  length in beats.
- note_out  output  NOTE_W  current note code.
- note_valid  output  1  tone generator must sound note_out.
- note_done  output  1  one-cycle pulse per retired entry.
- busy  output  1  state != IDLE or buffer full.

Behaviour:
- Reset (async, reset=0): state IDLE, buffer empty, note_out=0, note_valid=0, note_done=0, counters 0; in_ready forced 0 while reset=0.
- Handshake: in_ready = !buf_full. Accept on in_valid&&in_ready into the one-entry buffer. The buffer is never loaded and drained in the same cycle, because in_ready=0 when full.
- States: IDLE, ARMED, PLAY, GAP.
- IDLE, buffer full: pop into cur_note/cur_dur.
  - dur==0: pulse note_done next cycle, stay IDLE.
  - Otherwise: go to ARMED.
  - note_out=0 in IDLE.
- ARMED: note_out=cur_note, note_valid=0. On beat&&play: go to PLAY, rem=cur_dur.
- PLAY: note_valid = play. On beat&&play: rem-1. On the beat where rem==1 the note ends, note_done pulses next cycle, then:
  - GAP_BEATS>0: go to GAP, gap_cnt=GAP_BEATS, note_valid=0.
  - Else, buffer full with nonzero duration: pop, stay PLAY, rem=new dur, note_out changes next cycle. No note_valid drop.
  - Else: go to IDLE. A zero-duration buffered entry is retired by IDLE.
- GAP: note_valid=0, note_out holds. On beat&&play: gap_cnt-1. At 1, apply the same buffer check as above: PLAY (immediate) or IDLE.
- Beat counting and pause:
  - A note therefore spans exactly cur_dur beat periods, measured beat to beat.
  - play=0 in any state: beats ignored, rem/gap_cnt frozen, note_valid=0. The handshake and buffer continue to operate.
  - Resuming mid-note continues the remaining count.
- Timing and width rules:
  - An entry accepted in the same cycle as an end-of-note beat with the buffer empty misses the gapless path. It goes IDLE, then ARMED, and waits for the next beat.
  - beat asserted two consecutive cycles counts twice (caller contract: single-cycle pulse).
  - Duration range 1..2^DUR_W-1. rem is DUR_W bits, no wrap. GAP counter is sized from GAP_BEATS.
  - note_done is registered: exactly one pulse per retired entry, including zero-duration entries.
- Reset mid-operation: immediate return to reset values; the buffered entry is discarded.

Decomposition:
- Package beat_sched_pkg:
  - state encoding (IDLE=0, ARMED=1, PLAY=2, GAP=3);
  - default NOTE_W/DUR_W;
  - packed entry type {note, duration}.
- Sub-module note_skid_buf: one-entry valid/ready holding register with push/pop and full flag, same clk/reset.
- FSM and counters live in beat_scheduler.

Test Plan:
- Bench beat is 1 pulse per 4 clk; play=1 unless stated.
1. Reset release, push {0x15, dur 3} -> note_valid high for exactly 12 cycles starting the cycle after the first beat, note_out=0x15, one note_done pulse after the 3rd beat, busy=0 afterwards.
2. GAP_BEATS=0, push {0x0A,2} then {0x0C,1} -> in_ready=0 while 0x0C is buffered; note_out switches 0x0A to 0x0C with no note_valid low cycle; 8 cycles of 0x0A then 4 of 0x0C; two note_done pulses.
3. GAP_BEATS=1, same stimulus -> note_valid low for exactly 4 cycles between notes, note_out=0x0A during the gap.
4. Push {0x07,0} -> one note_done pulse, note_valid never asserted, back in IDLE within 3 cycles.
5. {0x11,4}, play=0 for 10 cycles after the 2nd beat -> note_valid low during the pause, beats ignored, total sounding time still 4 beat periods.
6. Assert reset mid-note with a buffered entry -> note_valid, note_out and busy are 0 immediately (async); in_ready=0 during reset and 1 after; the buffered entry is never played.
